axis_i2c_arbiter: RTL and testbench
===================================

AXIS_I2C_ARBITER -- requirements
Module: axis_i2c_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, giving the number of AXI-Stream requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, giving the command word width toward the I2C master.
REQ-003 SHALL have parameter TIMEOUT, default 1024, giving the idle-cycle limit inside a granted packet.
REQ-004 SHALL have port clk_i, input, 1: single clock for all logic.
REQ-005 SHALL have port arst_i, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port s_tdata_i, input, N_REQ*DATA_WIDTH: requester words, slot k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port s_tvalid_i, input, N_REQ: per-requester valid.
REQ-008 SHALL have port s_tlast_i, input, N_REQ: per-requester end-of-transaction marker.
REQ-009 SHALL have port s_tready_o, output, N_REQ: per-requester ready.
REQ-010 SHALL have ports m_tdata_o (output, DATA_WIDTH), m_tvalid_o (output, 1) and m_tready_i (input, 1): stream to the I2C master s_axis.
REQ-011 SHALL have ports i2c_tdata_i (input, DATA_WIDTH) and i2c_tvalid_i (input, 1): read data from the I2C master.
REQ-012 SHALL have ports rsp_tdata_o (output, DATA_WIDTH) and rsp_tvalid_o (output, N_REQ): read data routed back to its owner.
REQ-013 SHALL have ports timeout_o (output, 1), a one-cycle pulse, and timeout_id_o (output, $clog2(N_REQ)), the id of the aborted requester.

Function
REQ-014 SHALL implement FSM states IDLE and BUSY.
REQ-015 In IDLE, SHALL drive all s_tready_o and m_tvalid_o to 0.
REQ-016 In IDLE with any s_tvalid_i set, SHALL choose the winner round-robin starting at rr_ptr, register gnt, load owner, and enter BUSY the next cycle. Arbitration latency is 1 cycle.
REQ-017 In BUSY, SHALL set m_tdata_o to slot gnt of s_tdata_i, m_tvalid_o to s_tvalid_i[gnt] and s_tready_o[gnt] to m_tready_i, with all other s_tready_o bits 0. The data path SHALL be combinational, with zero added latency.
REQ-018 SHALL return from BUSY to IDLE on a handshake with s_tlast_i[gnt]=1, setting rr_ptr to (gnt+1) mod N_REQ.
REQ-019 SHALL keep an idle counter that clears on every handshake, increments while s_tvalid_i[gnt]=0 in BUSY, and holds while m_tvalid_o=1 and m_tready_i=0 (downstream backpressure does not count).
REQ-020 When the idle counter reaches TIMEOUT-1 and increments, SHALL go to IDLE, pulse timeout_o for 1 cycle, set timeout_id_o to gnt, and set rr_ptr to gnt+1.
REQ-021 SHALL drive rsp_tdata_o from i2c_tdata_i and rsp_tvalid_o[owner] from i2c_tvalid_i, with all other bits 0.
REQ-022 SHALL drop responses (rsp_tvalid_o all 0) until the first grant, tracked by an owner_vld flag.
REQ-023 SHALL keep owner unchanged until the next grant; a response in the same cycle as a new grant goes to the previous owner.
REQ-024 SHALL pass a single-beat packet (tvalid and tlast together) in one handshake, returning to IDLE the following cycle.
REQ-025 SHALL ignore requesters that deassert tvalid before being granted; no state is retained for them.

Reset
REQ-026 On arst_i high, SHALL force state=IDLE, gnt=0, rr_ptr=0, owner=0, owner_vld=0, idle counter=0 and timeout_o=0 immediately, without waiting for a clock edge.
REQ-027 Reset mid-packet SHALL abort the packet without a timeout pulse; the first post-reset arbitration starts at requester 0.

Structure
REQ-028 SHALL place the state enum (IDLE, BUSY) and the TIMEOUT default in package axis_i2c_arb_pkg.
REQ-029 SHALL implement winner selection in sub-module rr_arbiter: combinational, inputs req[N_REQ] and ptr, output one-hot grant and its index.

Verification
REQ-030 Requesters 0 and 2 both request 2-beat packets from IDLE -> req0 wins, beats 0x0101 and 0x0102 appear on m_tdata_o, then req2 is granted and rr_ptr=3.
REQ-031 All 4 requesters hold tvalid continuously with 1-beat packets -> grant order 0,1,2,3,0.
REQ-032 With TIMEOUT=16, req1 sends 1 beat without tlast, then idles -> timeout_o pulses after 16 idle cycles with timeout_id_o=1, and the FSM returns to IDLE.
REQ-033 m_tready_i is held low for 100 cycles mid-packet with TIMEOUT=16 -> no timeout, and the packet completes intact.
REQ-034 req3 completes a read packet, then i2c_tvalid_i pulses with 0x00A5 -> rsp_tvalid_o=4'b1000 and rsp_tdata_o=0x00A5; the same pulse before any grant -> rsp_tvalid_o=0.
REQ-035 arst_i is asserted during beat 2 of a req2 packet -> all outputs go to 0 asynchronously, and the next grant with all requesting goes to req0.

Source files
------------

// File: rtl/axis_i2c_arb_pkg.sv
// rtl/axis_i2c_arb_pkg.sv - shared types and defaults for the AXI-Stream I2C arbiter
package axis_i2c_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int TIMEOUT_DEF = 1024;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner select starting at ptr_i
module rr_arbiter
  import axis_i2c_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IW-1:0]    idx_o
);

  int j;

  // Walk from farthest to nearest so the requester closest to ptr_i wins last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    j       = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr_i) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (req_i[j[IW-1:0]]) begin
        grant_o            = '0;
        grant_o[j[IW-1:0]] = 1'b1;
        idx_o              = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/axis_i2c_arbiter.sv
// rtl/axis_i2c_arbiter.sv - packet-level round-robin arbiter of AXI-Stream requesters onto one I2C master
module axis_i2c_arbiter
  import axis_i2c_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                        clk_i,
  input  logic                        arst_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_tdata_i,
  input  logic [N_REQ-1:0]            s_tvalid_i,
  input  logic [N_REQ-1:0]            s_tlast_i,
  output logic [N_REQ-1:0]            s_tready_o,
  output logic [DATA_WIDTH-1:0]       m_tdata_o,
  output logic                        m_tvalid_o,
  input  logic                        m_tready_i,
  input  logic [DATA_WIDTH-1:0]       i2c_tdata_i,
  input  logic                        i2c_tvalid_i,
  output logic [DATA_WIDTH-1:0]       rsp_tdata_o,
  output logic [N_REQ-1:0]            rsp_tvalid_o,
  output logic                        timeout_o,
  output logic [$clog2(N_REQ)-1:0]    timeout_id_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            owner_vld_q, owner_vld_d;
  logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
  logic            timeout_q, timeout_d;
  logic [IW-1:0]   timeout_id_q, timeout_id_d;

  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             busy, sel_valid, sel_last, hs;
  logic [IW-1:0]    next_ptr;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_arbiter (
    .req_i   (s_tvalid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  assign busy      = (state_q == BUSY);
  assign sel_valid = s_tvalid_i[gnt_q];
  assign sel_last  = s_tlast_i[gnt_q];
  assign hs        = busy & sel_valid & m_tready_i;
  assign next_ptr  = IW'(wrap_inc(int'(gnt_q), N_REQ));

  always_comb begin
    m_tvalid_o        = busy & sel_valid;
    m_tdata_o         = busy ? s_tdata_i[gnt_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    s_tready_o        = '0;
    s_tready_o[gnt_q] = busy & m_tready_i;
  end

  // Read data follows the last granted owner, not the live grant.
  always_comb begin
    rsp_tdata_o           = i2c_tdata_i;
    rsp_tvalid_o          = '0;
    rsp_tvalid_o[owner_q] = owner_vld_q & i2c_tvalid_i;
  end

  assign timeout_o    = timeout_q;
  assign timeout_id_o = timeout_id_q;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    owner_vld_d  = owner_vld_q;
    idle_cnt_d   = idle_cnt_q;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;
    case (state_q)
      IDLE: begin
        if (|arb_grant) begin
          gnt_d       = arb_idx;
          owner_d     = arb_idx;
          owner_vld_d = 1'b1;
          idle_cnt_d  = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (hs) begin
          idle_cnt_d = '0;
          if (sel_last) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (!sel_valid) begin
          // Only requester silence counts; downstream stall holds the counter.
          if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
            state_d      = IDLE;
            timeout_d    = 1'b1;
            timeout_id_d = gnt_q;
            rr_ptr_d     = next_ptr;
            idle_cnt_d   = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      owner_vld_q  <= 1'b0;
      idle_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      owner_vld_q  <= owner_vld_d;
      idle_cnt_q   <= idle_cnt_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

endmodule

// File: tb/tb_axis_i2c_arbiter.sv
// tb/tb_axis_i2c_arbiter.sv - self-checking bench for axis_i2c_arbiter
module tb_axis_i2c_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            arst = 1'b0;
  logic [N*DW-1:0] s_tdata = '0;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tlast = '0;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tready = 1'b0;
  logic [DW-1:0]   i2c_tdata = '0;
  logic            i2c_tvalid = 1'b0;
  logic [DW-1:0]   rsp_tdata;
  logic [N-1:0]    rsp_tvalid;
  logic            tmo;
  logic [1:0]      tmo_id;

  axis_i2c_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .s_tdata_i    (s_tdata),
    .s_tvalid_i   (s_tvalid),
    .s_tlast_i    (s_tlast),
    .s_tready_o   (s_tready),
    .m_tdata_o    (m_tdata),
    .m_tvalid_o   (m_tvalid),
    .m_tready_i   (m_tready),
    .i2c_tdata_i  (i2c_tdata),
    .i2c_tvalid_i (i2c_tvalid),
    .rsp_tdata_o  (rsp_tdata),
    .rsp_tvalid_o (rsp_tvalid),
    .timeout_o    (tmo),
    .timeout_id_o (tmo_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [16:0] srcq [N][$];
  logic [N-1:0] hs = '0;
  logic [DW-1:0] beats[$];
  int grant_log[$];
  int hs_cyc = 0, tmo_cyc = 0, tmo_seen = 0;

  int mb = 0, mg = 0, mp = 0, mo = 0, mov = 0, mi = 0, mt = 0, mtid = 0, mtmo = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requester sources: each pops its head beat after an observed handshake.
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < N; k++) begin
      if (hs[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
      if (srcq[k].size() > 0) begin
        s_tvalid[k]          = 1'b1;
        s_tdata[k*DW +: DW]  = srcq[k][0][15:0];
        s_tlast[k]           = srcq[k][0][16];
      end else begin
        s_tvalid[k]          = 1'b0;
        s_tdata[k*DW +: DW]  = '0;
        s_tlast[k]           = 1'b0;
      end
    end
  end

  // Packet-level reference: who owns the bus, whose turn is next, how long the owner has been silent.
  always @(posedge clk or posedge arst) begin : model
    int w;
    if (arst) begin
      mb <= 0; mg <= 0; mp <= 0; mo <= 0; mov <= 0; mi <= 0; mt <= 0; mtid <= 0;
    end else begin
      mt <= 0;
      if (mb == 0) begin
        w = -1;
        for (int i = 0; i < N; i++)
          if (w < 0 && s_tvalid[(mp + i) % N]) w = (mp + i) % N;
        if (w >= 0) begin
          mb <= 1; mg <= w; mo <= w; mov <= 1; mi <= 0;
          grant_log.push_back(w);
        end
      end else if (s_tvalid[mg] && m_tready) begin
        mi <= 0;
        if (s_tlast[mg]) begin mb <= 0; mp <= (mg + 1) % N; end
      end else if (!s_tvalid[mg]) begin
        if (mi + 1 == TO) begin
          mb <= 0; mt <= 1; mtid <= mg; mp <= (mg + 1) % N; mi <= 0; mtmo <= mtmo + 1;
        end else begin
          mi <= mi + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_tvalid", m_tvalid, mb != 0 ? s_tvalid[mg] : 1'b0);
    chk("m_tdata", m_tdata, mb != 0 ? s_tdata[mg*DW +: DW] : 16'h0);
    chk("s_tready", s_tready, mb != 0 ? (4'(m_tready) << mg) : 4'd0);
    chk("rsp_tvalid", rsp_tvalid, mov != 0 ? (4'(i2c_tvalid) << mo) : 4'd0);
    chk("rsp_tdata", rsp_tdata, i2c_tdata);
    chk("timeout", tmo, mt != 0);
    chk("timeout_id", tmo_id, mtid);
    if (m_tvalid && m_tready) begin
      beats.push_back(m_tdata);
      hs_cyc <= cyc;
    end
    if (tmo) begin
      tmo_cyc  <= cyc;
      tmo_seen <= tmo_seen + 1;
    end
    hs <= s_tvalid & s_tready;
  end

  task automatic push(input int k, input logic [15:0] d, input logic last);
    srcq[k].push_back({last, d});
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(posedge clk); #3;
      if (mb == 0 && srcq[0].size() == 0 && srcq[1].size() == 0 &&
          srcq[2].size() == 0 && srcq[3].size() == 0) ok = 1;
    end
    chk(nm, ok, 1'b1);
  endtask

  task automatic wait_beats(input string nm, input int cnt, input int budget);
    bit ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(posedge clk); #3;
      if (beats.size() >= cnt) ok = 1;
    end
    chk(nm, ok, 1'b1);
  endtask

  task automatic chk_list(input string nm, input int act[$], input int exp[$]);
    chk({nm, "_len"}, act.size() >= exp.size(), 1'b1);
    for (int i = 0; i < exp.size(); i++)
      chk(nm, i < act.size() ? act[i] : -1, exp[i]);
  endtask

  initial begin
    int bl[$];
    #1 arst = 1'b1;
    i2c_tvalid = 1'b1;
    i2c_tdata  = 16'h00A5;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_s_tready", s_tready, 4'd0);
    chk("rst_rsp_tvalid", rsp_tvalid, 4'd0);
    chk("rst_timeout", tmo, 1'b0);
    i2c_tvalid = 1'b0;
    arst = 1'b0;

    // Response before any grant is dropped.
    @(posedge clk); #3;
    i2c_tvalid = 1'b1;
    #1 chk("pregrant_rsp", rsp_tvalid, 4'd0);
    @(posedge clk); #3;
    i2c_tvalid = 1'b0;

    // Two 2-beat packets from req0 and req2.
    m_tready = 1'b1;
    beats.delete(); grant_log.delete();
    push(0, 16'h0101, 0); push(0, 16'h0102, 1);
    push(2, 16'h0201, 0); push(2, 16'h0202, 1);
    wait_done("t1_done", 60);
    chk_list("t1_grant", grant_log, '{0, 2});
    chk("t1_rr_ptr", mp, 3);
    bl.delete(); foreach (beats[i]) bl.push_back(int'(beats[i]));
    chk_list("t1_beats", bl, '{'h0101, 'h0102, 'h0201, 'h0202});

    // Fresh reset, then all four hold tvalid with 1-beat packets.
    @(posedge clk); #3 arst = 1'b1;
    @(posedge clk); #3 arst = 1'b0;
    beats.delete(); grant_log.delete();
    for (int k = 0; k < N; k++) begin
      push(k, 16'(k << 8), 1);
      push(k, 16'((k << 8) | 1), 1);
    end
    wait_done("t2_done", 100);
    chk_list("t2_grant", grant_log, '{0, 1, 2, 3, 0, 1, 2, 3});
    bl.delete(); foreach (beats[i]) bl.push_back(int'(beats[i]));
    chk_list("t2_beats", bl, '{'h0000, 'h0100, 'h0200, 'h0300, 'h0001, 'h0101, 'h0201, 'h0301});

    // req1 sends one beat without tlast and goes silent.
    beats.delete();
    push(1, 16'h1111, 0);
    begin
      bit ok = 0;
      for (int n = 0; n < 60 && !ok; n++) begin
        @(posedge clk); #3;
        if (tmo_seen >= 1) ok = 1;
      end
      chk("t3_timeout_seen", ok, 1'b1);
    end
    chk("t3_pulse_delay", tmo_cyc - hs_cyc, 17);
    chk("t3_timeout_id", tmo_id, 2'd1);
    chk("t3_model_id", mtid, 1);
    chk("t3_model_idle", mb, 0);
    @(posedge clk); #3;
    chk("t3_pulse_once", tmo_seen, 1);

    // 100 cycles of downstream stall mid-packet must not time out.
    beats.delete();
    push(2, 16'h2201, 0); push(2, 16'h2202, 0); push(2, 16'h2203, 1);
    wait_beats("t4_first_beat", 1, 20);
    m_tready = 1'b0;
    repeat (100) @(posedge clk);
    #3 m_tready = 1'b1;
    wait_done("t4_done", 30);
    chk("t4_no_timeout", tmo_seen, 1);
    bl.delete(); foreach (beats[i]) bl.push_back(int'(beats[i]));
    chk_list("t4_beats", bl, '{'h2201, 'h2202, 'h2203});
    chk("t4_beat_count", beats.size(), 3);

    // req3 read packet, then response routed to req3.
    push(3, 16'h3301, 1);
    wait_done("t5_done", 20);
    @(posedge clk); #3;
    i2c_tvalid = 1'b1;
    i2c_tdata  = 16'h00A5;
    #1;
    chk("t5_rsp_tvalid", rsp_tvalid, 4'b1000);
    chk("t5_rsp_tdata", rsp_tdata, 16'h00A5);
    @(posedge clk); #3;
    i2c_tvalid = 1'b0;
    i2c_tdata  = '0;

    // Reset during beat 2 of a req2 packet.
    beats.delete();
    push(2, 16'h2A01, 0); push(2, 16'h2A02, 0); push(2, 16'h2A03, 1);
    wait_beats("t6_first_beat", 1, 20);
    chk("t6_pre_m_tvalid", m_tvalid, 1'b1);
    arst = 1'b1;
    #1;
    chk("t6_m_tvalid", m_tvalid, 1'b0);
    chk("t6_m_tdata", m_tdata, 16'h0);
    chk("t6_s_tready", s_tready, 4'd0);
    chk("t6_timeout", tmo, 1'b0);
    chk("t6_rsp_tvalid", rsp_tvalid, 4'd0);
    for (int k = 0; k < N; k++) srcq[k].delete();
    @(posedge clk); #3 arst = 1'b0;
    grant_log.delete();
    for (int k = 0; k < N; k++) push(k, 16'(16'h4000 | k), 1);
    wait_done("t6_done", 40);
    chk_list("t6_grant", grant_log, '{0, 1, 2, 3});
    chk("t6_no_timeout", tmo_seen, 1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
